btn_conditioner: RTL and testbench

//  Front-end stage for all player push-buttons, placed between the board pins and the VGA game top.

---
 rtl/btn_pkg.sv | 17 +
 rtl/debounce_channel.sv | 69 ++++++
 rtl/btn_conditioner.sv | 35 +++
 tb/tb_btn_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: channel index map and default debounce time.
package btn_pkg;

    localparam int BTN_LEFT            = 0;
    localparam int BTN_RIGHT           = 1;
    localparam int BTN_JUMP            = 2;
    localparam int BTN_DOWN            = 3;
    localparam int NUM_BTN_DEF         = 4;

    // 10 ms at the 65 MHz pixel clock
    localparam int DEBOUNCE_CYCLES_DEF = 650_000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, and registered press/release pulses.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic press,
    output logic rls
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
    end

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q, press_d;
    logic             rls_q, rls_d;

    always_comb begin
        sync_d  = {sync_q[0], in};
        level_d = level_q;
        cnt_d   = cnt_q;
        // Any sample agreeing with the current level restarts the stability window.
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
        rls_d       = ~level_q & level_dly_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            rls_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            rls_q       <= rls_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rls   = rls_q;

endmodule

// File: rtl/btn_conditioner.sv
// Player push-button front end: optional polarity inversion, then one independent debouncer per pin.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    logic [NUM_BTN-1:0] btn_in;

    // Normalise to 1 = pressed before the synchroniser so everything downstream is polarity-free.
    assign btn_in = btn_raw ^ {NUM_BTN{ACTIVE_LOW}};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .in    (btn_in[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rls   (btn_release[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random stimulus, checked against a behavioural model.
module tb_btn_conditioner;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] btn_raw_n;
    logic [3:0] lvl_a, prs_a, rel_a;
    logic [3:0] lvl_b, prs_b, rel_b;

    always #5 clk = ~clk;
    assign btn_raw_n = ~btn_raw;

    btn_conditioner #(.NUM_BTN(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a));

    btn_conditioner #(.NUM_BTN(4), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .btn_raw(btn_raw_n),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a pin's pressed state is seen two edges late; the level flips once the
    // seen state has disagreed with it for D consecutive edges; pulses trail by one edge.
    logic [3:0] m_lvl, m_prs, m_rel, m_rise, m_fall;
    int         m_run[4];
    logic [3:0] m_dly[$];

    task automatic model_reset();
        m_lvl = '0; m_prs = '0; m_rel = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_dly = {};
        m_dly.push_back(4'h0);
        m_dly.push_back(4'h0);
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] s;
        s = m_dly.pop_front();
        m_dly.push_back(raw);
        m_prs  = m_rise;
        m_rel  = m_fall;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_lvl[i] = s[i];
                    m_run[i] = 0;
                    if (s[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic cmp_all();
        chk("lvl_hi", 32'(lvl_a), 32'(m_lvl));
        chk("prs_hi", 32'(prs_a), 32'(m_prs));
        chk("rel_hi", 32'(rel_a), 32'(m_rel));
        chk("lvl_lo", 32'(lvl_b), 32'(m_lvl));
        chk("prs_lo", 32'(prs_b), 32'(m_prs));
        chk("rel_lo", 32'(rel_b), 32'(m_rel));
    endtask

    // Called at a negedge (or just after); returns at the following negedge.
    task automatic tick(input logic [3:0] raw);
        btn_raw = raw;
        @(posedge clk);
        if (!rst) model_edge(raw);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic apply_reset(input logic [3:0] raw, input int n, input bit chk_now);
        btn_raw = raw;
        rst = 1'b1;
        #1;
        model_reset();
        if (chk_now) cmp_all();
        repeat (n) tick(raw);
        rst = 1'b0;
    endtask

    int n1, n2, cp, cr, cq;

    initial begin
        model_reset();
        @(negedge clk);

        // 1: held buttons through reset
        apply_reset(4'hF, 5, 1'b0);
        n1 = -1; n2 = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(4'hF);
            if (lvl_a == 4'hF && n1 < 0) n1 = k;
            if (prs_a == 4'hF && n2 < 0) n2 = k;
        end
        chk("s1_lvl_cyc", n1, 10);
        chk("s1_prs_cyc", n2, 11);
        repeat (14) tick(4'h0);

        // 2: clean press on bit 3
        n1 = -1; cp = 0; cq = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(4'h8);
            if (lvl_a[3] && n1 < 0) n1 = k;
            cp += int'(prs_a[3]);
            cq += int'(prs_a[2:0] != 3'b0);
        end
        chk("s2_lat", n1, 10);
        chk("s2_npress", cp, 1);
        chk("s2_quiet", cq, 0);

        // 3: bounce on bit 0 with bit 3 held
        cp = 0; cr = 0; n1 = -1;
        for (int r = 0; r < 5; r++) begin
            repeat (3) begin tick(4'h9); cp += int'(prs_a[0]); cr += int'(rel_a[0]); end
            repeat (2) begin tick(4'h8); cp += int'(prs_a[0]); cr += int'(rel_a[0]); end
        end
        for (int k = 1; k <= 14; k++) begin
            tick(4'h9);
            if (lvl_a[0] && n1 < 0) n1 = k;
            cp += int'(prs_a[0]);
            cr += int'(rel_a[0]);
        end
        chk("s3_lat", n1, 10);
        chk("s3_npress", cp, 1);
        chk("s3_nrel", cr, 0);

        // 4: release bit 3
        n1 = -1; cp = 0; cr = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(4'h1);
            if (!lvl_a[3] && n1 < 0) n1 = k;
            cp += int'(prs_a[3]);
            cr += int'(rel_a[3]);
        end
        chk("s4_lat", n1, 10);
        chk("s4_nrel", cr, 1);
        chk("s4_npress", cp, 0);
        repeat (14) tick(4'h0);

        // 5: glitches on bit 2, one cycle short of and exactly the debounce time
        cp = 0; cr = 0;
        repeat (D - 1) begin tick(4'h4); cp += int'(prs_a[2] | lvl_a[2]); cr += int'(rel_a[2]); end
        repeat (14)    begin tick(4'h0); cp += int'(prs_a[2] | lvl_a[2]); cr += int'(rel_a[2]); end
        chk("s5_short_any", cp + cr, 0);
        cp = 0; cr = 0;
        repeat (D)  begin tick(4'h4); cp += int'(prs_a[2]); cr += int'(rel_a[2]); end
        repeat (14) begin tick(4'h0); cp += int'(prs_a[2]); cr += int'(rel_a[2]); end
        chk("s5_full_prs", cp, 1);
        chk("s5_full_rel", cr, 1);

        // 6: reset in the middle of bit 1's debounce
        cp = 0;
        repeat (7) begin tick(4'h2); cp += int'(prs_a[1]); end
        apply_reset(4'h2, 2, 1'b1);
        chk("s6_no_pulse", cp + int'(prs_a[1]), 0);
        n1 = -1;
        for (int k = 1; k <= 14; k++) begin
            tick(4'h2);
            if (lvl_a[1] && n1 < 0) n1 = k;
        end
        chk("s6_lat", n1, 10);
        repeat (14) tick(4'h0);

        // random segments, occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            logic [3:0] r;
            int         len;
            if ($urandom_range(0, 19) == 0) apply_reset(btn_raw, $urandom_range(1, 3), 1'b1);
            r   = 4'($urandom);
            len = $urandom_range(1, 12);
            repeat (len) tick(r);
        end
        repeat (14) tick(4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
